// File: rtl/tetris_line_clear.sv
// Line-clear sequencer: snapshots the playfield on piece lock, removes full rows
// bottom-up, and commits the collapsed field plus score during vertical blanking.
module tetris_line_clear #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] map_in,
    input  logic                 vblank,
    input  logic                 clear_score,
    output logic [ROWS*COLS-1:0] map_out,
    output logic [15:0]          score,
    output logic [4:0]           lines_cleared,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           fsm_state
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, WAIT_VB} state_t;

    state_t          state, state_next;
    logic [N-1:0]    w, w_next, shifted;
    logic [RW-1:0]   r, r_next;
    logic [4:0]      cnt, cnt_next;
    logic [IW-1:0]   row_lsb;
    logic            row_full, shifted_full, commit;
    logic [16:0]     sum;
    logic [15:0]     score_sum;

    function automatic logic [3:0] add_for(input logic [4:0] n);
        case (n)
            5'd0:    add_for = 4'd0;
            5'd1:    add_for = 4'd1;
            5'd2:    add_for = 4'd3;
            5'd3:    add_for = 4'd5;
            default: add_for = 4'd8;
        endcase
    endfunction

    // Row r of the snapshot and of the snapshot collapsed over row r.
    always_comb begin
        shifted = w;
        for (int y = 0; y < ROWS; y++) begin
            if (y == 0)
                shifted[0 +: COLS] = '0;
            else if (y <= int'(r))
                shifted[y*COLS +: COLS] = w[(y-1)*COLS +: COLS];
        end
        row_lsb      = IW'(int'(r) * COLS);
        row_full     = &w[row_lsb +: COLS];
        shifted_full = &shifted[row_lsb +: COLS];
    end

    always_comb begin
        sum       = {1'b0, score} + 17'(add_for(cnt));
        score_sum = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // SHIFT also evaluates the row it pulls into r, so each cleared row costs
    // a single extra cycle rather than a SHIFT plus a repeated SCAN.
    always_comb begin
        state_next = state;
        w_next     = w;
        r_next     = r;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    w_next     = map_in;
                    r_next     = RW'(ROWS - 1);
                    cnt_next   = 5'd0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (row_full)
                    state_next = SHIFT;
                else if (r == '0)
                    state_next = WAIT_VB;
                else
                    r_next = r - RW'(1);
            end
            SHIFT: begin
                w_next   = shifted;
                cnt_next = cnt + 5'd1;
                if (shifted_full)
                    state_next = SHIFT;
                else if (r == '0)
                    state_next = WAIT_VB;
                else begin
                    r_next     = r - RW'(1);
                    state_next = SCAN;
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            w             <= '0;
            r             <= RW'(ROWS - 1);
            cnt           <= 5'd0;
            map_out       <= '0;
            score         <= 16'd0;
            lines_cleared <= 5'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state <= state_next;
            w     <= w_next;
            r     <= r_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);
            done  <= commit;
            if (commit) begin
                map_out       <= w;
                lines_cleared <= cnt;
            end
            // A new game wins over the score of the commit in the same cycle.
            if (clear_score)
                score <= 16'd0;
            else if (commit)
                score <= score_sum;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed bench for tetris_line_clear: hand-computed playfields, latencies and
// scores checked against the committed outputs.
module tb_tetris_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         rst, start, vblank, clear_score;
    logic [N-1:0] map_in, map_out;
    logic [15:0]  score;
    logic [4:0]   lines_cleared;
    logic         busy, done;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .start(start), .map_in(map_in), .vblank(vblank),
        .clear_score(clear_score), .map_out(map_out), .score(score),
        .lines_cleared(lines_cleared), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] with_row(input logic [N-1:0] m, input int y,
                                              input logic [COLS-1:0] v);
        m[y*COLS +: COLS] = v;
        return m;
    endfunction

    task automatic launch(input logic [N-1:0] m);
        map_in = m;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Called #1 after the start edge; n counts edges from that edge to commit.
    task automatic collect(input string tag, input int exp_lat, input logic [4:0] exp_lines,
                           input logic [15:0] exp_sc);
        int n = 0;
        logic [N-1:0] exp_map;
        check({tag, "_busy_on"}, N'(busy), N'(1));
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        exp_map = exp_q.pop_front();
        check({tag, "_latency"}, N'(n), N'(exp_lat));
        check({tag, "_map"}, map_out, exp_map);
        check({tag, "_lines"}, N'(lines_cleared), N'(exp_lines));
        check({tag, "_score"}, N'(score), N'(exp_sc));
        check({tag, "_busy_off"}, N'(busy), N'(0));
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] exp_map,
                          input int exp_lat, input logic [4:0] exp_lines,
                          input logic [15:0] exp_sc);
        exp_q.push_back(exp_map);
        launch(m);
        collect(tag, exp_lat, exp_lines, exp_sc);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, N'(done), N'(0));
    endtask

    logic [N-1:0] m, e, prev_map;
    logic         stable, held, seen;

    initial begin
        rst = 1'b1; start = 1'b0; vblank = 1'b1; clear_score = 1'b0; map_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_map", map_out, '0);
        check("rst_score", N'(score), N'(0));
        check("rst_lines", N'(lines_cleared), N'(0));
        check("rst_busy", N'(busy), N'(0));
        check("rst_done", N'(done), N'(0));
        check("rst_state", N'(fsm_state), N'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Bottom row one cell short: nothing clears.
        m = with_row('0, 19, 10'h3FE);
        run_op("empty", m, m, 21, 5'd0, 16'd0);

        m = with_row(with_row('0, 19, 10'h3FF), 18, 10'h001);
        run_op("single", m, with_row('0, 19, 10'h001), 22, 5'd1, 16'd1);

        m = with_row('0, 15, 10'h155);
        for (int y = 16; y < 20; y++) m = with_row(m, y, 10'h3FF);
        run_op("tetris", m, with_row('0, 19, 10'h155), 25, 5'd4, 16'd9);

        m = with_row(with_row(with_row('0, 19, 10'h3FF), 18, 10'h0F0), 17, 10'h3FF);
        run_op("noncontig", m, with_row('0, 19, 10'h0F0), 23, 5'd2, 16'd12);

        run_op("all_full", '1, '0, 41, 5'd20, 16'd20);

        // Back-to-back: second start lands on the edge where done is high.
        exp_q.push_back(with_row('0, 19, 10'h001));
        launch(with_row('0, 19, 10'h001));
        collect("b2b_a", 21, 5'd0, 16'd20);
        m = with_row(with_row('0, 19, 10'h300), 0, 10'h3FF);
        exp_q.push_back(with_row('0, 19, 10'h300));
        launch(m);
        collect("b2b_b", 22, 5'd1, 16'd21);
        @(posedge clk); #1;

        // Vblank gating with ignored starts while busy.
        vblank = 1'b0;
        m = with_row(with_row('0, 19, 10'h2AA), 5, 10'h3FF);
        launch(m);
        prev_map = map_out;
        stable = 1'b1; held = 1'b1; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 40 || c == 60) begin
                map_in = '1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (map_out !== prev_map) stable = 1'b0;
            if (busy !== 1'b1) held = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        check("gate_map_stable", N'(stable), N'(1));
        check("gate_busy_held", N'(held), N'(1));
        check("gate_no_done", N'(seen), N'(0));
        vblank = 1'b1;
        @(posedge clk); #1;
        check("gate_done", N'(done), N'(1));
        check("gate_map", map_out, with_row('0, 19, 10'h2AA));
        check("gate_lines", N'(lines_cleared), N'(1));
        check("gate_score", N'(score), N'(22));
        repeat (3) @(posedge clk);
        #1;
        check("gate_idle_after", N'(busy), N'(0));

        // Reset five cycles into a scan.
        m = with_row('0, 15, 10'h155);
        for (int y = 16; y < 20; y++) m = with_row(m, y, 10'h3FF);
        launch(m);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", N'(busy), N'(0));
        check("mid_rst_map", map_out, '0);
        check("mid_rst_score", N'(score), N'(0));
        check("mid_rst_lines", N'(lines_cleared), N'(0));
        seen = done;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("mid_rst_no_done", N'(seen), N'(0));

        // Saturation from a preloaded score near the top.
        force dut.score = 16'hFFFC;
        #1;
        release dut.score;
        #1;
        check("sat_preload", N'(score), N'(16'hFFFC));
        run_op("sat_tetris", m, with_row('0, 19, 10'h155), 25, 5'd4, 16'hFFFF);
        m = with_row(with_row('0, 19, 10'h3FF), 18, 10'h001);
        run_op("sat_hold", m, with_row('0, 19, 10'h001), 22, 5'd1, 16'hFFFF);

        // Score clear on the commit edge still commits the playfield.
        vblank = 1'b0;
        m = with_row(with_row('0, 19, 10'h3FF), 18, 10'h0F0);
        e = with_row('0, 19, 10'h0F0);
        launch(m);
        repeat (30) @(posedge clk);
        #1;
        check("clr_busy", N'(busy), N'(1));
        vblank = 1'b1; clear_score = 1'b1;
        @(posedge clk); #1;
        clear_score = 1'b0;
        check("clr_done", N'(done), N'(1));
        check("clr_score", N'(score), N'(0));
        check("clr_map", map_out, e);
        check("clr_lines", N'(lines_cleared), N'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
